// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: single-outstanding load/store initiator with alignment checks, lane steering, load extension and bus timeout
module lsu_mem_initiator #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_ctrl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt;
    logic        accept, is_word, is_half, illegal, misal, load_resp, go_req;
    logic [3:0]  be_nx;
    logic [31:0] wd_nx, lane, ext, rdata_nx;
    logic [1:0]  err_nx;
    assign req_ready  = state == IDLE;
    assign mem_req    = state == REQ;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && req_ready;
    assign is_word    = req_ctrl == 3'b000;
    assign is_half    = req_ctrl == 3'b001 || req_ctrl == 3'b011;
    assign illegal    = req_ctrl > 3'b100 || (req_we && (req_ctrl == 3'b011 || req_ctrl == 3'b100));
    assign misal      = (is_word && req_addr[1:0] != 2'b00) || (is_half && req_addr[0]);
    assign be_nx      = is_word ? 4'b1111 : is_half ? 4'b0011 << {req_addr[1], 1'b0} : 4'b0001 << req_addr[1:0];
    assign wd_nx      = is_word ? req_wdata : is_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
    assign lane       = mem_rdata >> {off_q, 3'b000};
    assign ext        = ctrl_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                        ctrl_q == 3'b011 ? {16'h0, lane[15:0]} :
                        ctrl_q == 3'b010 ? {{24{lane[7]}}, lane[7:0]} :
                        ctrl_q == 3'b100 ? {24'h0, lane[7:0]} : mem_rdata;
    always_comb begin
        state_nx  = state;
        err_nx    = 2'b00;
        rdata_nx  = 32'h0;
        load_resp = 1'b0;
        go_req    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_nx  = (illegal || misal) ? RESP : REQ;
                err_nx    = illegal ? 2'b10 : misal ? 2'b01 : 2'b00;
                load_resp = illegal || misal;
                go_req    = !(illegal || misal);
            end
            REQ:  state_nx = mem_gnt ? WAIT : REQ;
            WAIT: if (mem_rvalid) begin
                state_nx  = RESP;
                rdata_nx  = we_q ? 32'h0 : ext;
                load_resp = 1'b1;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
                state_nx  = RESP;
                err_nx    = 2'b11;
                load_resp = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            ctrl_q     <= 3'b000;
            off_q      <= 2'b00;
            cnt        <= 8'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 2'b00;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            state <= state_nx;
            cnt   <= state == WAIT ? cnt + 8'h1 : 8'h0;
            if (accept) begin
                we_q   <= req_we;
                ctrl_q <= req_ctrl;
                off_q  <= req_addr[1:0];
            end
            if (go_req) begin
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_we    <= req_we;
                mem_be    <= be_nx;
                mem_wdata <= wd_nx;
            end
            if (load_resp) begin
                resp_rdata <= rdata_nx;
                resp_err   <= err_nx;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: vector table plus scoreboard of expected responses, with hand-written timeout and reset sequences
module tb_lsu_mem_initiator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [1:0]  resp_err;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    int          total = 0, bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr, wdata, mrd;
        int          gdly;
        logic [3:0]  be;
        logic [31:0] wd, rdata;
        logic [1:0]  err;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;
    vec_t tbl[16];
    exp_t q[$];

    lsu_mem_initiator #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_ctrl(req_ctrl),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_resp: got resp_valid=1 want no response at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {30'h0, resp_err}, {30'h0, e.err});
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mrd, input int gdly,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] rdata, input logic [1:0] err);
        vec_t v;
        v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.mrd = mrd; v.gdly = gdly;
        v.be = be; v.wd = wd; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic drive_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        chk("req_ready", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        e.rdata = v.rdata;
        e.err = v.err;
        q.push_back(e);
        drive_req(v.we, v.ctrl, v.addr, v.wdata);
        @(negedge clk);
        if (v.err != 2'b00) begin
            chk("err_mem_req", {31'h0, mem_req}, 32'h0);
            chk("err_latency", {31'h0, resp_valid}, 32'h1);
        end else begin
            for (int i = 0; i <= v.gdly; i++) begin
                if (i > 0) @(negedge clk);
                chk("mem_req", {31'h0, mem_req}, 32'h1);
                chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                chk("mem_be", {28'h0, mem_be}, {28'h0, v.be});
                chk("mem_we", {31'h0, mem_we}, {31'h0, v.we});
                chk("mem_wdata", mem_wdata, v.wd);
                if (i == v.gdly) mem_gnt = 1'b1;
                @(posedge clk);
                #1;
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = v.mrd;
            @(negedge clk);
            chk("wait_mem_req", {31'h0, mem_req}, 32'h0);
            chk("wait_no_resp", {31'h0, resp_valid}, 32'h0);
            @(posedge clk);
            #1 mem_rvalid = 1'b0; mem_rdata = 32'h0;
            @(negedge clk);
            chk("ok_latency", {31'h0, resp_valid}, 32'h1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic grant_now();
        @(negedge clk);
        chk("seq_mem_req", {31'h0, mem_req}, 32'h1);
        mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
    endtask

    initial begin
        int n;
        exp_t e;
        tbl[0]  = mk(1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0,        2'b00);
        tbl[1]  = mk(0, 3'b010, 32'h13, 32'h0,        32'h80FF7F01, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 2'b00);
        tbl[2]  = mk(0, 3'b100, 32'h13, 32'h0,        32'h80FF7F01, 0, 4'b1000, 32'h0,        32'h00000080, 2'b00);
        tbl[3]  = mk(0, 3'b001, 32'h02, 32'h0,        32'h80011234, 0, 4'b1100, 32'h0,        32'hFFFF8001, 2'b00);
        tbl[4]  = mk(0, 3'b011, 32'h02, 32'h0,        32'h80011234, 3, 4'b1100, 32'h0,        32'h00008001, 2'b00);
        tbl[5]  = mk(0, 3'b000, 32'h05, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b01);
        tbl[6]  = mk(1, 3'b011, 32'h00, 32'h1234,     32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b10);
        tbl[7]  = mk(1, 3'b000, 32'h20, 32'h12345678, 32'hFFFFFFFF, 3, 4'b1111, 32'h12345678, 32'h0,        2'b00);
        tbl[8]  = mk(1, 3'b010, 32'h21, 32'h000000AB, 32'h0,        0, 4'b0010, 32'hABABABAB, 32'h0,        2'b00);
        tbl[9]  = mk(1, 3'b001, 32'h32, 32'h12345678, 32'h0,        1, 4'b1100, 32'h56785678, 32'h0,        2'b00);
        tbl[10] = mk(0, 3'b100, 32'h11, 32'h0,        32'h80FF7F01, 0, 4'b0010, 32'h0,        32'h0000007F, 2'b00);
        tbl[11] = mk(0, 3'b000, 32'h40, 32'h0,        32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678, 2'b00);
        tbl[12] = mk(0, 3'b111, 32'h00, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b10);
        tbl[13] = mk(0, 3'b001, 32'h01, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b01);
        tbl[14] = mk(1, 3'b100, 32'h03, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b10);
        tbl[15] = mk(0, 3'b010, 32'h12, 32'h0,        32'h80FF7F01, 2, 4'b0100, 32'h0,        32'hFFFFFFFF, 2'b00);

        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {30'h0, resp_err}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 16; i++) run(tbl[i]);

        // rvalid in the last allowed WAIT cycle beats the timeout
        e.rdata = 32'hCAFEF00D; e.err = 2'b00; q.push_back(e);
        drive_req(0, 3'b000, 32'h44, 32'h0);
        grant_now();
        repeat (15) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("race_no_resp_yet", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        @(negedge clk);
        chk("race_resp", {31'h0, resp_valid}, 32'h1);
        @(posedge clk);
        #1;

        // no rvalid: timeout after exactly 16 WAIT cycles
        e.rdata = 32'h0; e.err = 2'b11; q.push_back(e);
        drive_req(0, 3'b000, 32'h48, 32'h0);
        grant_now();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk("timeout_wait_cycles", n, 16);
        @(posedge clk);
        #1;

        // reset while in REQ drops mem_req asynchronously
        drive_req(1, 3'b000, 32'h50, 32'h11);
        #2 reset = 1'b1;
        #1;
        chk("rstreq_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rstreq_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;

        // reset while in WAIT aborts without a response
        drive_req(0, 3'b000, 32'h54, 32'h0);
        grant_now();
        #2 reset = 1'b1;
        #1;
        chk("rstwait_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rstwait_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rstwait_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // stray memory handshakes in IDLE are ignored
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h55AA55AA;
        repeat (3) begin
            @(negedge clk);
            chk("stray_resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("stray_mem_req", {31'h0, mem_req}, 32'h0);
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the CPU memory stage and a word-organised data memory port.
- Accepts one load/store request at a time and checks alignment and access type.
- Converts the request into a word address, byte enables and lane-shifted write data, then handshakes with memory.
- Returns sign/zero-extended load data, or an error code, to the pipeline.

Parameters:
- ADDR_W, 32, width of req_addr and mem_addr.
- TIMEOUT, 16, maximum cycles in WAIT before a bus-timeout error; valid range 1..255.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE; a transfer happens when req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  access type: 000 word, 001 signed half, 010 signed byte, 011 unsigned half, 100 unsigned byte.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  error code: 00 ok, 01 misaligned, 10 illegal ctrl, 11 timeout.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepted the request.
- mem_addr  out  ADDR_W  word address (bits [1:0] = 00).
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-positioned write data.
- mem_rvalid  in  1  memory completion; also acts as the store acknowledge.
- mem_rdata  in  32  raw memory word.

Behaviour:
- Reset values: state IDLE; req_ready 1; resp_valid 0; resp_rdata 0; resp_err 00; mem_req 0; mem_we 0; mem_be 0; mem_addr 0; mem_wdata 0; timeout counter 0.
- Reset mid-operation aborts immediately: mem_req drops asynchronously and no response is issued.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, on accept:
  - Register we, ctrl, addr[1:0] and wdata.
  - Illegal ctrl (101..111, or a store with 011/100) -> RESP with err 10.
  - Misaligned (word with addr[1:0]≠0, half with addr[0]≠0) -> RESP with err 01.
  - Otherwise -> REQ.
  - Error paths never assert mem_req.
- REQ:
  - mem_req=1 with mem_addr, mem_we, mem_be and mem_wdata all held stable until mem_gnt.
  - On mem_gnt -> WAIT; mem_req deasserts the cycle after the grant.
- Byte enables and write data:
  - word: be=1111.
  - half: be=0011<<(2*addr[1]), data = {2{wdata[15:0]}}.
  - byte: be=0001<<addr[1:0], data = {4{wdata[7:0]}}.
  - Loads drive be to the same pattern with mem_we=0.
- WAIT:
  - The counter increments every cycle.
  - On mem_rvalid: capture rdata and select the lane with addr[1:0].
    - Signed half/byte: sign-extend. Unsigned: zero-extend. Word: pass through.
    - Stores return 0.
    - Go to RESP with err 00.
  - If the counter reaches TIMEOUT with no rvalid -> RESP with err 11.
  - mem_rvalid on the same cycle the counter reaches TIMEOUT wins (err 00).
- RESP: resp_valid=1 for exactly one cycle, then IDLE and the counter clears.
- resp_rdata and resp_err hold their values until the next response.
- mem_rvalid or mem_gnt outside REQ/WAIT is ignored.
- Minimum latency (grant in the first REQ cycle, rvalid the next cycle): accept at cycle 0, mem_req at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
- Error latency: accept at cycle 0, resp_valid at cycle 1.
- Back-to-back: the next request can be accepted in the cycle after RESP.

Test Plan:
- Store word: addr 0x0000_0010, wdata 0xDEADBEEF, grant immediately, rvalid next cycle -> mem_addr 0x10, be 1111, mem_wdata 0xDEADBEEF, mem_we 1; resp_valid at cycle 3, err 00, rdata 0.
- Load signed byte: addr 0x13, mem_rdata 0x80FF_7F01 -> be 1000, resp_rdata 0xFFFF_FF80. Repeat with ctrl 100 -> 0x0000_0080.
- Load signed half: addr 0x2, mem_rdata 0x8001_1234 -> resp_rdata 0xFFFF_8001. Unsigned (011) -> 0x0000_8001.
- Misaligned word load at 0x5, plus store with ctrl 011 -> no mem_req; resp_valid at cycle 1 with err 01 and 10 respectively.
- Grant held low for 3 cycles -> mem_req and address stable throughout. With rvalid never asserted and TIMEOUT=16 -> err 11 exactly 16 WAIT cycles after the grant.
- Assert reset while in WAIT -> mem_req 0 and req_ready 1 immediately, no resp_valid. A stray mem_rvalid in IDLE produces no response.
